// File: rtl/uart_rx_os16.sv
// -----------------------------------------------------------------------------
// uart_rx_os16 -- 16x oversampling UART receiver with a one-entry holding
// register drained through a valid/ready handshake.
//
// The line is brought into the clock domain by a SYNC_STAGES-deep
// synchronizer. Each bit period is 16 ticks of tick_16x_i. Three samples are
// taken at tick counts 7, 8 and 9, and their majority decides the bit. Data is
// shifted in LSB first. A completed byte is loaded into the holding register,
// unless that register is still full, in which case the byte is dropped and
// the sticky overrun flag is raised.
//
// Optional feature macro: UART_RX_PARITY_EN
//   When this macro is defined, an even-parity bit follows the data bits and
//   the parity_err_o port is added. When it is undefined, frames are
//   1 start + DATA_BITS data + 1 stop bit, which is 8N1 by default.
//
// Parameters:
//   DATA_BITS    data bits per frame (5..8)
//   SYNC_STAGES  flip-flops in the rxd synchronizer (>= 2)
//
// Ports:
//   clk_i         system clock (the only clock)
//   rst_i         synchronous active-high reset
//   tick_16x_i    one-clk strobe at 16x baud; all bit timing advances on it
//   rxd_i         asynchronous serial input, idles high
//   rx_data_o     holding-register contents, valid while rx_valid_o=1
//   rx_valid_o    holding register full
//   rx_ready_i    consumer accepts rx_data_o when rx_valid_o && rx_ready_i
//   frame_err_o   one-clk pulse when a stop bit is sampled low
//   parity_err_o  one-clk pulse on even-parity mismatch (UART_RX_PARITY_EN)
//   overrun_o     sticky: a completed byte was dropped; cleared only by rst_i
// -----------------------------------------------------------------------------
module uart_rx_os16 #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 tick_16x_i,
    input  logic                 rxd_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 frame_err_o,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err_o,
`endif
    output logic                 overrun_o
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY    = 3'd3;
`endif
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

    // Tick-count landmarks within one bit period
    localparam logic [3:0] TC_SAMPLE_A = 4'd7;
    localparam logic [3:0] TC_SAMPLE_B = 4'd8;
    localparam logic [3:0] TC_DECIDE   = 4'd9;
    localparam logic [3:0] TC_LAST     = 4'd15;

    localparam int               IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

`ifdef UART_RX_PARITY_EN
    // Even parity: the parity bit equals the XOR of all data bits.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction
`endif

    // -------------------------------------------------------------------------
    // Signals
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs_s;

    logic [2:0]             state_q,  state_d;
    logic [3:0]             tc_q,     tc_d;
    logic [IDX_W-1:0]       idx_q,    idx_d;
    logic [DATA_BITS-1:0]   shift_q,  shift_d;
    logic                   samp_a_q, samp_a_d;
    logic                   samp_b_q, samp_b_d;
    logic                   decision_s;
    logic                   complete_s;
    logic                   consume_s;

    logic [DATA_BITS-1:0]   rx_data_q,   rx_data_d;
    logic                   rx_valid_q,  rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q,   overrun_d;
`ifdef UART_RX_PARITY_EN
    logic                   par_bad_q,    par_bad_d;
    logic                   parity_err_q, parity_err_d;
`endif

    // Synchronizer: shifts rxd_i through SYNC_STAGES flops, all reset to idle-high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd_i};
        end
    end

    assign rxs_s      = sync_q[SYNC_STAGES-1];
    // The third sample is the live value on the tc=9 tick itself.
    assign decision_s = maj3(samp_a_q, samp_b_q, rxs_s);
    assign consume_s  = rx_valid_q & rx_ready_i;

    // Receive FSM next-state: bit timing, voting samples, shift register.
    always_comb begin
        state_d     = state_q;
        tc_d        = tc_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        samp_a_d    = samp_a_q;
        samp_b_d    = samp_b_q;
        complete_s  = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d   = par_bad_q;
`endif
        if (tick_16x_i) begin
            tc_d = tc_q + 4'd1;

            if (tc_q == TC_SAMPLE_A) begin
                samp_a_d = rxs_s;
            end else begin
                samp_a_d = samp_a_q;
            end

            if (tc_q == TC_SAMPLE_B) begin
                samp_b_d = rxs_s;
            end else begin
                samp_b_d = samp_b_q;
            end

            case (state_q)
                ST_IDLE: begin
                    // tc is parked at 0 so the first START tick counts from 0.
                    tc_d = 4'd0;
                    if (!rxs_s) begin
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end

                ST_START: begin
                    if ((tc_q == TC_DECIDE) && decision_s) begin
                        // Line went back high mid start bit: a glitch.
                        state_d = ST_IDLE;
                    end else if (tc_q == TC_LAST) begin
                        state_d = ST_DATA;
                        idx_d   = {IDX_W{1'b0}};
                    end else begin
                        state_d = ST_START;
                    end
                end

                ST_DATA: begin
                    if (tc_q == TC_DECIDE) begin
                        // LSB arrives first, so shift toward bit 0.
                        shift_d = {decision_s, shift_q[DATA_BITS-1:1]};
                    end else if (tc_q == TC_LAST) begin
                        if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            idx_d = idx_q + IDX_ONE;
                        end
                    end else begin
                        shift_d = shift_q;
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tc_q == TC_DECIDE) begin
                        par_bad_d = decision_s ^ even_parity(shift_q);
                    end else if (tc_q == TC_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        par_bad_d = par_bad_q;
                    end
                end
`endif

                ST_STOP: begin
                    if (tc_q == TC_DECIDE) begin
                        if (decision_s) begin
                            // Leave at mid stop bit to gain slack for the next start.
                            complete_s = 1'b1;
                            state_d    = ST_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = ST_WAIT_HIGH;
                        end
                    end else begin
                        state_d = ST_STOP;
                    end
                end

                ST_WAIT_HIGH: begin
                    // Hold off until the line idles so a break is not a start.
                    tc_d = 4'd0;
                    if (rxs_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_HIGH;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    tc_d    = 4'd0;
                end
            endcase
        end else begin
            state_d = state_q;
            tc_d    = tc_q;
        end
    end

    // Holding register, handshake and status flags.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
`ifdef UART_RX_PARITY_EN
        parity_err_d = complete_s & par_bad_q;
`endif
        if (complete_s) begin
            if (!rx_valid_q || rx_ready_i) begin
                // Empty, or emptied on this very edge: take the new byte.
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d  = 1'b1;
            end
        end else if (consume_s) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            tc_q        <= 4'd0;
            idx_q       <= {IDX_W{1'b0}};
            shift_q     <= {DATA_BITS{1'b0}};
            samp_a_q    <= 1'b1;
            samp_b_q    <= 1'b1;
            rx_data_q   <= {DATA_BITS{1'b0}};
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tc_q        <= tc_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            samp_a_q    <= samp_a_d;
            samp_b_q    <= samp_b_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = parity_err_q;
`endif

endmodule
